// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx between N_REQ byte producers, with optional source header and ack timeout.
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter bit HEADER_EN = 1'b1,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           data_to_tx,
  output logic                 start_tx,
  input  logic                 tx_busy,
  output logic [3:0]           grant_id,
  output logic                 arb_busy,
  output logic                 timeout_err
);
  typedef enum logic [2:0] {IDLE, SEND_HDR, ACK_HDR, DONE_HDR, SEND_DAT, ACK_DAT, DONE_DAT} state_t;
  state_t state;
  logic busy_m, busy_s;
  logic [3:0] ptr, win, idx;
  logic [4:0] sum;
  logic [7:0] byte_q;
  logic [15:0] cnt;
  logic [15:0] valid_pad;
  logic [127:0] data_pad;
  assign valid_pad = 16'(req_valid);
  assign data_pad = 128'(req_data);
  // Scan downward so the lowest offset from ptr is the last (winning) assignment.
  always_comb begin
    win = ptr;
    sum = '0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + 5'(i);
      idx = sum >= 5'(N_REQ) ? 4'(sum - 5'(N_REQ)) : sum[3:0];
      if (valid_pad[idx]) win = idx;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy_m <= 1'b0;
      busy_s <= 1'b0;
      ptr <= '0;
      byte_q <= '0;
      cnt <= '0;
      req_ready <= '0;
      data_to_tx <= '0;
      start_tx <= 1'b0;
      grant_id <= '0;
      arb_busy <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      busy_m <= tx_busy;
      busy_s <= busy_m;
      req_ready <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (|req_valid && !busy_s) begin
          byte_q <= data_pad[{win, 3'b000} +: 8];
          grant_id <= win;
          ptr <= (win == 4'(N_REQ - 1)) ? 4'd0 : win + 4'd1;
          req_ready <= N_REQ'(1) << win;
          arb_busy <= 1'b1;
          state <= HEADER_EN ? SEND_HDR : SEND_DAT;
        end
        SEND_HDR, SEND_DAT: begin
          data_to_tx <= (state == SEND_HDR) ? {4'hA, grant_id} : byte_q;
          start_tx <= 1'b1;
          cnt <= '0;
          state <= (state == SEND_HDR) ? ACK_HDR : ACK_DAT;
        end
        ACK_HDR, ACK_DAT: if (busy_s) begin
          start_tx <= 1'b0;
          state <= (state == ACK_HDR) ? DONE_HDR : DONE_DAT;
        end else if (cnt == 16'(ACK_TIMEOUT)) begin
          start_tx <= 1'b0;
          timeout_err <= 1'b1;
          arb_busy <= 1'b0;
          state <= IDLE;
        end else begin
          cnt <= cnt + 16'd1;
        end
        DONE_HDR: if (!busy_s) state <= SEND_DAT;
        DONE_DAT: if (!busy_s) begin
          arb_busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a queue-based round-robin model and a uart_tx model.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic [3:0] req_valid, req_ready, grant_id;
  logic [31:0] req_data;
  logic [7:0] data_to_tx;
  logic start_tx, tx_busy, arb_busy, timeout_err;
  logic [3:0] req_valid_1, req_ready_1, grant_id_1;
  logic [31:0] req_data_1;
  logic [7:0] data_to_tx_1;
  logic start_tx_1, tx_busy_1, arb_busy_1, timeout_err_1;
  int checks = 0, errors = 0;
  logic [7:0] pbuf [4][64];
  int phead[4] = '{0, 0, 0, 0};
  int ptail[4] = '{0, 0, 0, 0};
  int grant_log[$], exp_grants[$];
  logic [7:0] line_log[$], exp_bytes[$];
  int mptr = 0;
  int extra = 0;
  bit alive = 1'b1;
  time fell_t = 0;
  logic prev_start;
  logic [7:0] prev_data;

  uart_tx_arbiter #(.N_REQ(4), .HEADER_EN(1'b1), .ACK_TIMEOUT(10)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .data_to_tx(data_to_tx), .start_tx(start_tx), .tx_busy(tx_busy), .grant_id(grant_id),
    .arb_busy(arb_busy), .timeout_err(timeout_err));
  uart_tx_arbiter #(.N_REQ(4), .HEADER_EN(1'b0), .ACK_TIMEOUT(10)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid_1), .req_data(req_data_1), .req_ready(req_ready_1),
    .data_to_tx(data_to_tx_1), .start_tx(start_tx_1), .tx_busy(tx_busy_1), .grant_id(grant_id_1),
    .arb_busy(arb_busy_1), .timeout_err(timeout_err_1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      pbuf[i][ptail[i]] = 8'($urandom);
      ptail[i]++;
    end
  endtask

  task automatic clear_exp();
    grant_log.delete();
    line_log.delete();
    exp_grants.delete();
    exp_bytes.delete();
  endtask

  // Drain copies of the producer queues in round-robin order from mptr.
  task automatic model();
    int h[4];
    int w;
    h = phead;
    while (1) begin
      w = -1;
      for (int k = 3; k >= 0; k--)
        if (h[(mptr + k) % 4] < ptail[(mptr + k) % 4]) w = (mptr + k) % 4;
      if (w < 0) break;
      exp_grants.push_back(w);
      exp_bytes.push_back(8'hA0 | 8'(w));
      exp_bytes.push_back(pbuf[w][h[w]]);
      h[w]++;
      mptr = (w + 1) % 4;
    end
  endtask

  task automatic expect_end(input string tag);
    int n = 0;
    while (!(line_log.size() >= exp_bytes.size() && !arb_busy && !tx_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(n < 3000), 1);
    repeat (20) @(negedge clk);
    chk({tag, "_ngrant"}, grant_log.size(), exp_grants.size());
    chk({tag, "_nbyte"}, line_log.size(), exp_bytes.size());
    for (int k = 0; k < exp_grants.size() && k < grant_log.size(); k++)
      chk({tag, "_grant"}, grant_log[k], exp_grants[k]);
    for (int k = 0; k < exp_bytes.size() && k < line_log.size(); k++)
      chk({tag, "_byte"}, line_log[k], exp_bytes[k]);
  endtask

  // Producers: present queue head, pop on req_ready.
  initial begin
    req_valid = '0;
    req_data = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i] && phead[i] < ptail[i]) phead[i]++;
        req_valid[i] = phead[i] < ptail[i];
        req_data[8*i +: 8] = pbuf[i][phead[i]];
      end
    end
  end

  initial begin
    prev_start = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("ready_onehot", 32'($onehot0(req_ready)), 1);
        if (|req_ready) grant_log.push_back($clog2(req_ready));
        if (start_tx && prev_start) chk("data_stable", data_to_tx, prev_data);
      end
      prev_start = start_tx;
      prev_data = data_to_tx;
    end
  end

  // uart_tx model: one frame per observed start, busy for a random length.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (alive && start_tx && !reset) begin
        line_log.push_back(data_to_tx);
        @(negedge clk);
        tx_busy = 1'b1;
        repeat ($urandom_range(5, 12) + extra) @(negedge clk);
        tx_busy = 1'b0;
        fell_t = $time;
      end
    end
  end

  initial begin
    int n, a, b;
    reset = 1'b1;
    req_valid_1 = '0;
    req_data_1 = '0;
    tx_busy_1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 4'h0);
    chk("rst_data", data_to_tx, 8'h00);
    chk("rst_start", start_tx, 1'b0);
    chk("rst_grant", grant_id, 4'h0);
    chk("rst_busy", arb_busy, 1'b0);
    chk("rst_tmo", timeout_err, 1'b0);
    reset = 1'b0;

    req_valid_1 = 4'b0100;
    req_data_1 = 32'h005A_0000;
    n = 0;
    while (req_ready_1 == 4'h0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("single_ready", req_ready_1, 4'b0100);
    chk("single_grant", grant_id_1, 4'd2);
    chk("single_arb_busy", arb_busy_1, 1'b1);
    req_valid_1 = '0;
    @(negedge clk);
    chk("single_ready_pulse", req_ready_1, 4'h0);
    chk("single_start", start_tx_1, 1'b1);
    chk("single_data", data_to_tx_1, 8'h5A);
    tx_busy_1 = 1'b1;
    repeat (2) @(negedge clk);
    chk("single_start_hold", start_tx_1, 1'b1);
    @(negedge clk);
    chk("single_start_drop", start_tx_1, 1'b0);
    repeat (3) @(negedge clk);
    tx_busy_1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("single_done_wait", arb_busy_1, 1'b1);
    @(negedge clk);
    chk("single_idle", arb_busy_1, 1'b0);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      n += int'(start_tx_1);
    end
    chk("single_no_restart", n, 0);

    clear_exp();
    for (int i = 0; i < 4; i++) load(i, 2);
    model();
    expect_end("rr");

    clear_exp();
    load(0, 1);
    model();
    expect_end("skip_a");
    clear_exp();
    load(0, 1);
    load(3, 2);
    model();
    expect_end("skip_wrap");

    for (int r = 0; r < 6; r++) begin
      clear_exp();
      for (int i = 0; i < 4; i++) load(i, $urandom_range(0, 3));
      model();
      expect_end("rand");
    end

    a = mptr;
    b = (mptr + 1) % 4;
    clear_exp();
    alive = 1'b0;
    load(a, 1);
    load(b, 1);
    exp_grants.push_back(a);
    exp_grants.push_back(b);
    exp_bytes.push_back(8'hA0 | 8'(b));
    exp_bytes.push_back(pbuf[b][ptail[b] - 1]);
    mptr = (b + 1) % 4;
    n = 0;
    while (!start_tx && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_rise", start_tx, 1'b1);
    n = 0;
    while (start_tx && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_len", n, 11);
    chk("tmo_err", timeout_err, 1'b1);
    chk("tmo_idle", arb_busy, 1'b0);
    alive = 1'b1;
    @(negedge clk);
    chk("tmo_pulse", timeout_err, 1'b0);
    expect_end("tmo_next");

    extra = 20;
    clear_exp();
    load(mptr, 1);
    n = 0;
    while (!(line_log.size() == 2 && tx_busy && !start_tx) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach", 32'(n < 300), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_ready", req_ready, 4'h0);
    chk("mid_data", data_to_tx, 8'h00);
    chk("mid_start", start_tx, 1'b0);
    chk("mid_grant", grant_id, 4'h0);
    chk("mid_busy", arb_busy, 1'b0);
    chk("mid_tmo", timeout_err, 1'b0);
    mptr = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_line_busy", tx_busy, 1'b1);
    extra = 0;
    clear_exp();
    for (int i = 0; i < 4; i++) if (phead[i] == ptail[i]) load(i, 1);
    model();
    n = 0;
    while (!start_tx && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_gate", 32'($time - fell_t), 40);
    expect_end("mid_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
